// File: rtl/input_buffer_rd_ctrl.sv
// Read sequencer for the activation input buffer.
// Walks one feature-map row per pass with stride s and issues one read per
// NUM_RDATA-wide window. The final window of a row pops the remaining tail so
// the next row starts aligned at the buffer head. It also gates upstream
// loading from the buffer fill flags and reports layer completion.
module input_buffer_rd_ctrl #(
   parameter int unsigned NUM_RDATA     = 3,
   parameter int unsigned FF_ADDR_WIDTH = 4,
   parameter int unsigned ROW_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic [ROW_WIDTH-1:0]     i_row_len,
   input  logic [ROW_WIDTH-1:0]     i_num_rows,
   input  logic [1:0]               i_stride,
   input  logic                     i_pe_ready,
   input  logic [FF_ADDR_WIDTH:0]   i_buf_counter,
   input  logic                     i_buf_half,
   input  logic                     i_buf_full,
   input  logic                     i_buf_rd_vld,
   output logic                     o_buf_rd_req,
   output logic [FF_ADDR_WIDTH-1:0] o_buf_rd_step,
   output logic                     o_load_en,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_cfg_err
);

   // Wide enough that pos + s + NUM_RDATA and the buffer count never overflow.
   localparam int unsigned EXT_W = (ROW_WIDTH + 2 > FF_ADDR_WIDTH + 1) ?
                                   (ROW_WIDTH + 2) : (FF_ADDR_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DATA,
      ISSUE,
      WAIT_VLD,
      DONE
   } state_t;

   state_t               state;
   logic [ROW_WIDTH-1:0] row_len;
   logic [ROW_WIDTH-1:0] num_rows;
   logic [1:0]           stride;
   logic [ROW_WIDTH-1:0] pos;
   logic [ROW_WIDTH-1:0] row;
   logic                 final_rd;

   logic [EXT_W-1:0]         pos_ext;
   logic [EXT_W-1:0]         len_ext;
   logic [EXT_W-1:0]         s_ext;
   logic [EXT_W-1:0]         cnt_ext;
   logic [EXT_W-1:0]         step_ext;
   logic                     is_last;
   logic                     data_ok;
   logic                     cfg_bad;
   logic [FF_ADDR_WIDTH-1:0] step;

   // Window geometry for the current pos: last-window detect and pop step.
   always_comb begin
      pos_ext  = EXT_W'(pos);
      len_ext  = EXT_W'(row_len);
      s_ext    = EXT_W'(stride);
      cnt_ext  = EXT_W'(i_buf_counter);
      is_last  = (pos_ext + s_ext + EXT_W'(NUM_RDATA)) > len_ext;
      step_ext = is_last ? (len_ext - pos_ext) : s_ext;
      step     = step_ext[FF_ADDR_WIDTH-1:0];
      data_ok  = i_pe_ready && (cnt_ext >= EXT_W'(NUM_RDATA)) && (cnt_ext >= step_ext);
      cfg_bad  = (i_row_len < ROW_WIDTH'(NUM_RDATA)) || (i_stride == 2'd0) ||
                 (i_num_rows == '0);
   end

   // Upstream may write only while a layer runs and the buffer has headroom.
   assign o_load_en = o_busy & ~i_buf_half & ~i_buf_full;

   // Sequencer FSM; pulse outputs are registered on entry to their state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         row_len       <= '0;
         num_rows      <= '0;
         stride        <= '0;
         pos           <= '0;
         row           <= '0;
         final_rd      <= 1'b0;
         o_buf_rd_req  <= 1'b0;
         o_buf_rd_step <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_cfg_err     <= 1'b0;
      end else begin
         o_buf_rd_req  <= 1'b0;
         o_buf_rd_step <= '0;
         o_done        <= 1'b0;
         o_cfg_err     <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  if (cfg_bad) begin
                     o_cfg_err <= 1'b1;
                  end else begin
                     row_len  <= i_row_len;
                     num_rows <= i_num_rows;
                     stride   <= i_stride;
                     pos      <= '0;
                     row      <= '0;
                     o_busy   <= 1'b1;
                     state    <= WAIT_DATA;
                  end
               end
            end
            WAIT_DATA: begin
               // pos is stable into ISSUE, so the step registered here is the one used there.
               if (data_ok) begin
                  o_buf_rd_req  <= 1'b1;
                  o_buf_rd_step <= step;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (is_last) begin
                  pos      <= '0;
                  row      <= row + ROW_WIDTH'(1);
                  final_rd <= (row == num_rows - ROW_WIDTH'(1));
               end else begin
                  pos      <= pos + ROW_WIDTH'(stride);
                  final_rd <= 1'b0;
               end
               state <= WAIT_VLD;
            end
            WAIT_VLD: begin
               if (i_buf_rd_vld) begin
                  if (final_rd) begin
                     o_done <= 1'b1;
                     state  <= DONE;
                  end else begin
                     state <= WAIT_DATA;
                  end
               end
            end
            DONE: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_buffer_rd_ctrl.sv
// Self-checking bench for input_buffer_rd_ctrl: a buffer model answers reads
// one cycle later and a queue of expected pop steps is checked per read.
module tb_input_buffer_rd_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start;
   logic [7:0] i_row_len;
   logic [7:0] i_num_rows;
   logic [1:0] i_stride;
   logic       i_pe_ready;
   logic [4:0] i_buf_counter;
   logic       i_buf_half;
   logic       i_buf_full;
   logic       i_buf_rd_vld;
   logic       o_buf_rd_req;
   logic [3:0] o_buf_rd_step;
   logic       o_load_en;
   logic       o_busy;
   logic       o_done;
   logic       o_cfg_err;

   input_buffer_rd_ctrl #(
      .NUM_RDATA     (3),
      .FF_ADDR_WIDTH (4),
      .ROW_WIDTH     (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_row_len     (i_row_len),
      .i_num_rows    (i_num_rows),
      .i_stride      (i_stride),
      .i_pe_ready    (i_pe_ready),
      .i_buf_counter (i_buf_counter),
      .i_buf_half    (i_buf_half),
      .i_buf_full    (i_buf_full),
      .i_buf_rd_vld  (i_buf_rd_vld),
      .o_buf_rd_req  (o_buf_rd_req),
      .o_buf_rd_step (o_buf_rd_step),
      .o_load_en     (o_load_en),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_cfg_err     (o_cfg_err)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   exp_q[$];
   int   n_req   = 0;
   int   n_done  = 0;
   int   popped  = 0;
   int   last_vld_cyc  = 0;
   int   first_req_cyc = -1;
   int   start_cyc     = 0;
   bit   vld_pend = 1'b0;
   bit   no_req   = 1'b0;
   bit   hold     = 1'b0;
   logic [4:0] buf_cnt = '0;

   assign i_buf_counter = hold ? 5'd2 : buf_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Buffer model and scoreboard: answer each read one cycle later, pop data,
   // and compare each issued step against the queue.
   always @(negedge clk) begin
      if (rst) begin
         vld_pend     = 1'b0;
         i_buf_rd_vld = 1'b0;
      end else begin
         i_buf_rd_vld = vld_pend;
         if (vld_pend) last_vld_cyc = cyc;
         vld_pend = o_buf_rd_req;
         if (o_buf_rd_req) begin
            n_req++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            chk("req_allowed", 32'(no_req), 0);
            chk("cnt_ge_step", 32'(i_buf_counter >= 5'(o_buf_rd_step)), 1);
            chk("cnt_ge_nrdata", 32'(i_buf_counter >= 5'd3), 1);
            chk("req_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("rd_step", 32'(o_buf_rd_step), exp_q.pop_front());
            popped += int'(o_buf_rd_step);
            if (!hold) buf_cnt = buf_cnt - 5'(o_buf_rd_step);
         end
         if (o_done) begin
            n_done++;
            chk("done_latency", cyc - last_vld_cyc, 1);
            chk("done_q_left", exp_q.size(), 0);
         end
      end
   end

   // Reference step list built by stepping windows until one no longer fits.
   task automatic push_steps(input int len, input int s, input int rows);
      for (int r = 0; r < rows; r++) begin
         int p = 0;
         while (p + s + 3 <= len) begin
            exp_q.push_back(s);
            p += s;
         end
         exp_q.push_back(len - p);
      end
   endtask

   task automatic start_layer(input int len, input int s, input int rows);
      @(negedge clk);
      i_row_len  = 8'(len);
      i_stride   = 2'(s);
      i_num_rows = 8'(rows);
      i_start    = 1'b1;
      start_cyc  = cyc;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(input int base, input int lim);
      int k = 0;
      while (n_done == base && k < lim) begin
         @(posedge clk);
         k++;
      end
      chk("done_count", n_done - base, 1);
      @(negedge clk);
   endtask

   task automatic wait_req(input int target, input int lim);
      int k = 0;
      while (n_req < target && k < lim) begin
         @(posedge clk);
         k++;
      end
      chk("req_reached", 32'(n_req >= target), 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base_done;
      int base_req;
      int rel_cyc;

      rst = 1'b1; i_start = 1'b0; i_row_len = '0; i_num_rows = '0; i_stride = '0;
      i_pe_ready = 1'b1; i_buf_half = 1'b0; i_buf_full = 1'b0; i_buf_rd_vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({o_buf_rd_req, o_buf_rd_step, o_load_en, o_busy, o_done, o_cfg_err}), 0);
      rst = 1'b0;

      // L=8, s=1, R=1: steps 1,1,1,1,1,3
      buf_cnt = 5'd8; popped = 0; first_req_cyc = -1;
      base_done = n_done; base_req = n_req;
      push_steps(8, 1, 1);
      start_layer(8, 1, 1);
      chk("busy_after_start", 32'(o_busy), 1);
      wait_done(base_done, 200);
      chk("first_read_latency", first_req_cyc - start_cyc, 2);
      chk("t1_reads", n_req - base_req, 6);
      chk("t1_popped", popped, 8);
      @(negedge clk);
      chk("t1_idle_busy", 32'(o_busy), 0);

      // L=8, s=2, R=2 with fill-flag gating and a PE stall
      buf_cnt = 5'd16; popped = 0;
      base_done = n_done; base_req = n_req;
      push_steps(8, 2, 2);
      start_layer(8, 2, 2);
      wait_req(base_req + 1, 50);
      @(negedge clk);
      chk("load_en_open", 32'(o_load_en), 1);
      i_buf_half = 1'b1; #1;
      chk("load_en_half", 32'(o_load_en), 0);
      i_buf_half = 1'b0; i_buf_full = 1'b1; #1;
      chk("load_en_full", 32'(o_load_en), 0);
      i_buf_full = 1'b0; #1;
      chk("load_en_reopen", 32'(o_load_en), 1);
      wait_req(base_req + 2, 50);
      @(negedge clk);
      i_pe_ready = 1'b0; no_req = 1'b1;
      repeat (5) @(negedge clk);
      chk("stall_busy", 32'(o_busy), 1);
      chk("stall_reads", n_req - base_req, 2);
      i_pe_ready = 1'b1; no_req = 1'b0;
      wait_done(base_done, 200);
      chk("t2_reads", n_req - base_req, 6);
      chk("t2_popped", popped, 16);

      // L=7, s=2: counter held at 2, then 7
      buf_cnt = 5'd7; hold = 1'b1; popped = 0; first_req_cyc = -1;
      base_done = n_done; base_req = n_req;
      push_steps(7, 2, 1);
      start_layer(7, 2, 1);
      repeat (20) @(negedge clk);
      chk("hold_no_reads", n_req - base_req, 0);
      rel_cyc = cyc;
      hold = 1'b0;
      wait_done(base_done, 200);
      chk("first_after_hold", 32'(first_req_cyc >= rel_cyc), 1);
      chk("t3_reads", n_req - base_req, 3);
      chk("t3_popped", popped, 7);

      // L=7, s=3: tail step 4 must wait for the counter to reach 4
      buf_cnt = 5'd6; popped = 0;
      base_done = n_done; base_req = n_req;
      push_steps(7, 3, 1);
      start_layer(7, 3, 1);
      wait_req(base_req + 1, 50);
      @(negedge clk);
      no_req = 1'b1;
      repeat (10) @(negedge clk);
      chk("tail_wait_cnt", 32'(i_buf_counter), 3);
      no_req = 1'b0;
      buf_cnt = buf_cnt + 5'd1;
      wait_done(base_done, 200);
      chk("t4_reads", n_req - base_req, 2);
      chk("t4_popped", popped, 7);

      // Illegal configs: L=2, then s=0, then R=0
      no_req = 1'b1;
      start_layer(2, 1, 1);
      chk("cfg_err_len", 32'({o_cfg_err, o_busy}), 32'b10);
      @(negedge clk);
      chk("cfg_err_pulse", 32'(o_cfg_err), 0);
      start_layer(8, 0, 1);
      chk("cfg_err_stride", 32'({o_cfg_err, o_busy}), 32'b10);
      start_layer(8, 1, 0);
      chk("cfg_err_rows", 32'({o_cfg_err, o_busy}), 32'b10);
      repeat (3) @(negedge clk);
      chk("cfg_err_idle", 32'(o_busy), 0);
      no_req = 1'b0;

      // Reset during WAIT_VLD of row 1, then a full replay
      buf_cnt = 5'd16;
      base_done = n_done; base_req = n_req;
      push_steps(8, 2, 2);
      start_layer(8, 2, 2);
      wait_req(base_req + 4, 100);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_outputs", 32'({o_buf_rd_req, o_buf_rd_step, o_load_en, o_busy, o_done, o_cfg_err}), 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      chk("abort_no_done", n_done - base_done, 0);
      buf_cnt = 5'd16; popped = 0;
      base_done = n_done; base_req = n_req;
      push_steps(8, 2, 2);
      start_layer(8, 2, 2);
      wait_done(base_done, 200);
      chk("replay_reads", n_req - base_req, 6);
      chk("replay_popped", popped, 16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
